// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, alu32 operation
// select codes, FSM state encoding and the decoded control bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SLT2 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin;
        logic [1:0] operation;
        logic       legal;
    } alu_ctl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the issue stage, its op source and its writeback consumer.
interface alu_issue_stage_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_cout;
    logic         out_ovf;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_cout, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_cout, out_ovf, out_err
    );
endinterface

// File: rtl/alu_issue_stage_alu32.sv
// 32-bit combinational ALU: invert/carry-in controlled adder plus AND/OR and LESS
// injection into bit 0. Also reports adder carry, signed overflow and the SLT set bit.
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_invert,
    input  logic        b_invert,
    input  logic        cin,
    input  logic [1:0]  operation,
    input  logic        less,
    output logic [31:0] result,
    output logic        cout,
    output logic        overflow,
    output logic        set
);
    logic [31:0] a_eff;
    logic [31:0] b_eff;
    logic [32:0] sum;

    always_comb begin
        a_eff    = a ^ {32{a_invert}};
        b_eff    = b ^ {32{b_invert}};
        sum      = {1'b0, a_eff} + {1'b0, b_eff} + {32'd0, cin};
        cout     = sum[32];
        overflow = (a_eff[31] ~^ b_eff[31]) & (sum[31] ^ a_eff[31]);
        // Overflow-corrected sign of the difference gives the signed compare.
        set      = sum[31] ^ overflow;
        case (operation)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = sum[31:0];
            default: result = {31'd0, less};
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue/execute stage: accepts one op per handshake, decodes it onto
// alu32 (SLT as SUB pass then LESS pass) and holds result/flags for writeback.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus
);
    state_e       state_q;
    logic [3:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         less_q;
    logic         valid_q;
    logic [W-1:0] res_q;
    logic         zero_q;
    logic         cout_q;
    logic         ovf_q;
    logic         err_q;

    alu_ctl_t     ctl;
    logic [W-1:0] alu_res;
    logic         alu_cout;
    logic         alu_ovf;
    logic         alu_set;
    logic         accept;
    logic         arith;
    logic [W-1:0] res_d;
    logic         zero_d;
    logic         cout_d;
    logic         ovf_d;

    function automatic alu_ctl_t decode(input logic [3:0] op, input state_e st);
        alu_ctl_t c;
        c       = '0;
        c.legal = 1'b1;
        if (st == ST_SLT2) begin
            c.b_inv = 1'b1; c.cin = 1'b1; c.operation = OP_LESS;
        end else begin
            case (op)
                ALU_AND: c.operation = OP_AND;
                ALU_OR:  c.operation = OP_OR;
                ALU_ADD: c.operation = OP_ADD;
                ALU_SUB, ALU_SLT: begin
                    c.b_inv = 1'b1; c.cin = 1'b1; c.operation = OP_ADD;
                end
                ALU_NOR: begin
                    c.a_inv = 1'b1; c.b_inv = 1'b1; c.operation = OP_AND;
                end
                default: c.legal = 1'b0;
            endcase
        end
        return c;
    endfunction

    assign ctl = decode(op_q, state_q);

    alu32 u_alu32 (
        .a         (a_q),
        .b         (b_q),
        .a_invert  (ctl.a_inv),
        .b_invert  (ctl.b_inv),
        .cin       (ctl.cin),
        .operation (ctl.operation),
        .less      (less_q),
        .result    (alu_res),
        .cout      (alu_cout),
        .overflow  (alu_ovf),
        .set       (alu_set)
    );

    // in_ready is held low for the whole reset so nothing is taken while rst is high.
    assign bus.in_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        arith  = (ctl.operation == OP_ADD);
        res_d  = alu_res;
        zero_d = (alu_res == '0);
        cout_d = arith ? alu_cout : 1'b0;
        ovf_d  = arith ? alu_ovf  : 1'b0;
        if (state_q == ST_SLT2) begin
            cout_d = alu_cout;
            ovf_d  = 1'b0;
        end
    end

    // Operand capture at the accept edge; SLT sign captured at the end of the SUB pass.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= bus.in_op;
            a_q  <= bus.in_a;
            b_q  <= bus.in_b;
        end
        if (state_q == ST_EXEC) begin
            less_q <= alu_set;
        end
    end

    // Control FSM with registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!ctl.legal) begin
                        res_q   <= '0;
                        zero_q  <= 1'b1;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (op_q == ALU_SLT) begin
                        state_q <= ST_SLT2;
                    end else begin
                        res_q   <= res_d;
                        zero_q  <= zero_d;
                        cout_q  <= cout_d;
                        ovf_q   <= ovf_d;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_SLT2: begin
                    res_q   <= res_d;
                    zero_q  <= zero_d;
                    cout_q  <= cout_d;
                    ovf_q   <= ovf_d;
                    err_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_cout   = cout_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table through a scoreboard, then backpressure,
// illegal-op and mid-op reset sequences.
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic z, input logic c,
                                input logic o, input logic e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.z = z; v.c = c; v.o = o; v.e = e; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = v.op;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        if (n < 20) sb.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic receive(input string tag);
        int   lat = 0;
        vec_t e;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".lat"},  32'(lat),            32'(e.lat));
            chk({tag, ".res"},  bus.out_result,      e.res);
            chk({tag, ".zero"}, 32'(bus.out_zero),   32'(e.z));
            chk({tag, ".cout"}, 32'(bus.out_cout),   32'(e.c));
            chk({tag, ".ovf"},  32'(bus.out_ovf),    32'(e.o));
            chk({tag, ".err"},  32'(bus.out_err),    32'(e.e));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   lat;
        int   dup;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b0;

        vecs[0]  = mk(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 1);
        vecs[1]  = mk(ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1, 0, 0, 1);
        vecs[2]  = mk(ALU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        vecs[3]  = mk(ALU_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 1, 0, 0, 2);
        vecs[4]  = mk(ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 0, 2);
        vecs[5]  = mk(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0, 1);
        vecs[6]  = mk(ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 0, 1);
        vecs[7]  = mk(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0, 1);
        vecs[8]  = mk(ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        vecs[9]  = mk(ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 0, 1);
        vecs[10] = mk(ALU_SLT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 0, 0, 0, 0, 2);

        repeat (2) @(negedge clk);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result",    bus.out_result,     32'd0);
        chk("rst.err",       32'(bus.out_err),   32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i]);
            receive($sformatf("vec%0d", i));
        end

        // Backpressure: hold the result for five cycles, then hand off straight into a new op.
        send(mk(ALU_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 1));
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("bp.valid", 32'(bus.out_valid), 32'd1);
        v = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_valid",    32'(bus.out_valid), 32'd1);
            chk("bp.hold_result",   bus.out_result,     v.res);
            chk("bp.hold_in_ready", 32'(bus.in_ready),  32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = ALU_OR;
        bus.in_a      = 32'h0000_00F0;
        bus.in_b      = 32'h0000_000F;
        #1;
        chk("bp.handoff_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(mk(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        receive("bp_next");
        dup = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) dup++;
        end
        chk("bp.no_duplicate", 32'(dup), 32'd0);
        chk("bp.sb_drained",   32'(sb.size()), 32'd0);

        send(mk(4'b1111, 32'h1234_5678, 32'h0000_0001, 32'd0, 1, 0, 0, 1, 1));
        receive("illegal");
        send(mk(ALU_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1));
        receive("after_illegal");

        // Reset while the SLT LESS pass is in flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = ALU_SLT;
        bus.in_a     = 32'h8000_0000;
        bus.in_b     = 32'h0000_0001;
        #1;
        chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst.result",    bus.out_result,     32'd0);
        chk("mid_rst.in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel.in_ready", 32'(bus.in_ready), 32'd1);
        dup = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid) dup++;
        end
        chk("mid_rel.dropped", 32'(dup), 32'd0);
        send(mk(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0, 1));
        receive("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
